// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller and its ALU.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
  } statetype;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef logic [1:0] aluop_t;
  localparam aluop_t ALUOP_ADD   = 2'b00;
  localparam aluop_t ALUOP_SUB   = 2'b01;
  localparam aluop_t ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: instruction fields and zero in, selects/enables out.
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;

  modport master (
    input  op, funct, zero,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol
  );

  modport slave (
    output op, funct, zero,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol
  );
endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: maps the controller's aluop (and funct for R-type) to the ALU function code.
module mc_aludec
  import mc_pkg::*;
(
  input  aluop_t     i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol
);

  always_comb begin
    o_alucontrol = ALU_AND;
    case (i_aluop)
      ALUOP_ADD: o_alucontrol = ALU_ADD;
      ALUOP_SUB: o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          F_ADD:   o_alucontrol = ALU_ADD;
          F_SUB:   o_alucontrol = ALU_SUB;
          F_AND:   o_alucontrol = ALU_AND;
          F_OR:    o_alucontrol = ALU_OR;
          F_SLT:   o_alucontrol = ALU_SLT;
          default: o_alucontrol = ALU_AND;
        endcase
      end
      default: o_alucontrol = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM (Moore); all datapath controls decode from state,
// with only pcen (zero) and alucontrol (funct) depending on live inputs.
module mc_controller
  import mc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mc_controller_if.master bus
);

  statetype r_state;
  statetype w_next;

  logic   w_pcwrite, w_branch;
  logic   w_iord, w_memwrite, w_irwrite, w_regdst, w_memtoreg, w_regwrite, w_alusrca;
  logic [1:0] w_alusrcb, w_pcsrc;
  aluop_t w_aluop;
  logic [2:0] w_alucontrol;

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH: w_next = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = RTYPEEX;
          OP_BEQ:       w_next = BEQEX;
          OP_ADDI:      w_next = ADDIEX;
          OP_J:         w_next = JEX;
          default:      w_next = FETCH;
        endcase
      end
      MEMADR:  w_next = (bus.op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   w_next = MEMWB;
      RTYPEEX: w_next = RTYPEWB;
      ADDIEX:  w_next = ADDIWB;
      default: w_next = FETCH;
    endcase
  end

  always_comb begin
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_pcsrc    = 2'b00;
    w_aluop    = ALUOP_ADD;
    case (r_state)
      FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        w_alusrcb = 2'b01;
      end
      DECODE: w_alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      MEMRD: w_iord = 1'b1;
      MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      RTYPEEX: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      BEQEX: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_SUB;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
      end
      ADDIWB: w_regwrite = 1'b1;
      JEX: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  mc_aludec u_aludec (
    .i_aluop      (w_aluop),
    .i_funct      (bus.funct),
    .o_alucontrol (w_alucontrol)
  );

  // Branch is taken in the same cycle the ALU compares, so zero gates pcen combinationally.
  assign bus.pcen       = w_pcwrite | (w_branch & bus.zero);
  assign bus.iord       = w_iord;
  assign bus.memwrite   = w_memwrite;
  assign bus.irwrite    = w_irwrite;
  assign bus.regdst     = w_regdst;
  assign bus.memtoreg   = w_memtoreg;
  assign bus.regwrite   = w_regwrite;
  assign bus.alusrca    = w_alusrca;
  assign bus.alusrcb    = w_alusrcb;
  assign bus.pcsrc      = w_pcsrc;
  assign bus.alucontrol = w_alucontrol;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed instruction table, reset corner cases, and
// random instruction streams checked against a per-instruction cycle script.
module tb_mc_controller;
  import mc_pkg::*;

  logic clk;
  logic reset;
  mc_controller_if bus();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alu;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         cpi;
    outs_t      exp_ex;
    outs_t      exp_last;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[14];

  localparam outs_t FETCH_V = 15'b1_0_0_1_0_0_0_0_01_00_010;

  function automatic outs_t sample();
    return {bus.pcen, bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
            bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol};
  endfunction

  task automatic chk(input string name, input outs_t act, input outs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Instruction-level reference: cycle count and control word at each step k.
  function automatic int ref_cpi(input logic [5:0] op);
    case (op)
      OP_LW:                       return 5;
      OP_SW, OP_RTYPE, OP_ADDI:    return 4;
      OP_BEQ, OP_J:                return 3;
      default:                     return 2;
    endcase
  endfunction

  function automatic logic [2:0] ref_funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic outs_t ref_out(input int k, input logic [5:0] op,
                                    input logic [5:0] f, input logic z);
    outs_t o;
    o = '0;
    o.alu = 3'b010;
    if (k == 0) return FETCH_V;
    if (k == 1) begin o.alusrcb = 2'b11; return o; end
    case (op)
      OP_LW, OP_SW, OP_ADDI: begin
        if (k == 2) begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
        else if (op == OP_ADDI) o.regwrite = 1'b1;
        else if (k == 3) begin
          o.iord = 1'b1;
          o.memwrite = (op == OP_SW);
        end else begin
          o.memtoreg = 1'b1; o.regwrite = 1'b1;
        end
      end
      OP_RTYPE: begin
        if (k == 2) begin o.alusrca = 1'b1; o.alu = ref_funct_alu(f); end
        else begin o.regdst = 1'b1; o.regwrite = 1'b1; end
      end
      OP_BEQ: begin
        o.alusrca = 1'b1; o.pcsrc = 2'b01; o.alu = 3'b110; o.pcen = z;
      end
      OP_J: begin
        o.pcsrc = 2'b10; o.pcen = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

  // Runs one instruction from step k0, starting just after the clock edge that enters step k0.
  // zmode: 0/1 fixed zero, 2 random zero each cycle. tidx >= 0 also checks table entries.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input int zmode,
                           input int k0, input int tidx, input string tag);
    int cpi;
    outs_t act;
    cpi = ref_cpi(op);
    bus.op = op;
    bus.funct = f;
    for (int k = k0; k < cpi; k++) begin
      bus.zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      @(negedge clk);
      act = sample();
      chk($sformatf("%s_k%0d", tag, k), act, ref_out(k, op, f, bus.zero));
      if (tidx >= 0) begin
        if (k == 2 && cpi > 2) chk($sformatf("%s_tbl_ex", tag), act, tbl[tidx].exp_ex);
        if (k == cpi - 1)      chk($sformatf("%s_tbl_last", tag), act, tbl[tidx].exp_last);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [5:0] rop, rf;
    logic [5:0] legal_ops [6];
    logic [5:0] functs [6];
    legal_ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
    functs    = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};

    tbl[0]  = '{OP_LW,    6'b0,      1'b0, 5, 15'b0_0_0_0_0_0_0_1_10_00_010, 15'b0_0_0_0_0_1_1_0_00_00_010};
    tbl[1]  = '{OP_SW,    6'b0,      1'b1, 4, 15'b0_0_0_0_0_0_0_1_10_00_010, 15'b0_1_1_0_0_0_0_0_00_00_010};
    tbl[2]  = '{OP_RTYPE, 6'b100000, 1'b0, 4, 15'b0_0_0_0_0_0_0_1_00_00_010, 15'b0_0_0_0_1_0_1_0_00_00_010};
    tbl[3]  = '{OP_RTYPE, 6'b100010, 1'b1, 4, 15'b0_0_0_0_0_0_0_1_00_00_110, 15'b0_0_0_0_1_0_1_0_00_00_010};
    tbl[4]  = '{OP_RTYPE, 6'b100100, 1'b0, 4, 15'b0_0_0_0_0_0_0_1_00_00_000, 15'b0_0_0_0_1_0_1_0_00_00_010};
    tbl[5]  = '{OP_RTYPE, 6'b100101, 1'b0, 4, 15'b0_0_0_0_0_0_0_1_00_00_001, 15'b0_0_0_0_1_0_1_0_00_00_010};
    tbl[6]  = '{OP_RTYPE, 6'b101010, 1'b0, 4, 15'b0_0_0_0_0_0_0_1_00_00_111, 15'b0_0_0_0_1_0_1_0_00_00_010};
    tbl[7]  = '{OP_RTYPE, 6'b111111, 1'b0, 4, 15'b0_0_0_0_0_0_0_1_00_00_000, 15'b0_0_0_0_1_0_1_0_00_00_010};
    tbl[8]  = '{OP_BEQ,   6'b0,      1'b1, 3, 15'b1_0_0_0_0_0_0_1_00_01_110, 15'b1_0_0_0_0_0_0_1_00_01_110};
    tbl[9]  = '{OP_BEQ,   6'b0,      1'b0, 3, 15'b0_0_0_0_0_0_0_1_00_01_110, 15'b0_0_0_0_0_0_0_1_00_01_110};
    tbl[10] = '{OP_ADDI,  6'b0,      1'b0, 4, 15'b0_0_0_0_0_0_0_1_10_00_010, 15'b0_0_0_0_0_0_1_0_00_00_010};
    tbl[11] = '{OP_SW,    6'b0,      1'b0, 4, 15'b0_0_0_0_0_0_0_1_10_00_010, 15'b0_1_1_0_0_0_0_0_00_00_010};
    tbl[12] = '{OP_J,     6'b0,      1'b0, 3, 15'b1_0_0_0_0_0_0_0_00_10_010, 15'b1_0_0_0_0_0_0_0_00_10_010};
    tbl[13] = '{6'b111111, 6'b0,     1'b0, 2, FETCH_V,                       15'b0_0_0_0_0_0_0_0_11_00_010};

    reset = 1'b1;
    bus.op = OP_LW;
    bus.funct = '0;
    bus.zero = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_state", sample(), FETCH_V);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_held", sample(), FETCH_V);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 14; i++)
      run_instr(tbl[i].op, tbl[i].funct, int'(tbl[i].zero), 0, i, $sformatf("tbl%0d", i));

    // Reset during MEMRD of lw: no MEMWB, straight back to FETCH.
    bus.op = OP_LW;
    bus.funct = '0;
    bus.zero = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("abort_k%0d", k), sample(), ref_out(k, OP_LW, 6'b0, 1'b0));
      if (k < 3) begin @(posedge clk); #1; end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_fetch", sample(), FETCH_V);
    @(posedge clk); #1;
    run_instr(OP_LW, 6'b0, 2, 1, -1, "abort_resume");

    // Random instruction stream with random zero every cycle.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) rop = 6'($urandom);
      else                           rop = legal_ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 1) == 0) rf = 6'($urandom);
      else                           rf = functs[$urandom_range(0, 5)];
      run_instr(rop, rf, 2, 0, -1, $sformatf("rnd%0d", n));
    end

    @(negedge clk);
    chk("final_fetch", sample(), FETCH_V);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle MIPS control unit; sequences each instruction through a Moore state machine and drives every datapath select/enable, including the 3-bit ALU function code consumed by the 32-bit ALU directly downstream. Sits between the instruction register (op/funct inputs) and the shared single-ALU multicycle datapath; the ALU `zero` flag returns to it for branch resolution.

## Interface
- No parameters; all widths fixed by the MIPS ISA.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- op  in  6  instruction[31:26] from the instruction register
- funct  in  6  instruction[5:0] from the instruction register
- zero  in  1  ALU zero flag (result == 0)
- pcen  out  1  PC register enable = pcwrite | (branch & zero)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  data memory write enable
- irwrite  out  1  instruction register load enable
- regdst  out  1  write-register select: 0 = rt, 1 = rd
- memtoreg  out  1  write-data select: 0 = ALUOut, 1 = memory data
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  ALU function: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
- Transitions: FETCH→DECODE. DECODE on op: 100011 (lw) or 101011 (sw) → MEMADR; 000000 → RTYPEEX; 000100 → BEQEX; 001000 → ADDIEX; 000010 → JEX; any other op → FETCH (executed as NOP, no writes). MEMADR → MEMRD if lw, MEMWR if sw. MEMRD→MEMWB. RTYPEEX→RTYPEWB. ADDIEX→ADDIWB. MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX → FETCH.
- op is sampled in DECODE and again in MEMADR; the instruction register holds it stable from FETCH's end until the next FETCH.
- Per-state outputs (all unlisted = 0; aluop is internal):
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00
  - DECODE: alusrcb=11, aluop=00
  - MEMADR, ADDIEX: alusrca=1, alusrcb=10, aluop=00
  - MEMRD: iord=1
  - MEMWB: memtoreg=1, regwrite=1
  - MEMWR: iord=1, memwrite=1
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10
  - RTYPEWB: regdst=1, regwrite=1
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1
  - ADDIWB: regwrite=1
  - JEX: pcsrc=10, pcwrite=1
- ALU decode: aluop 00 → 010; 01 → 110; 10 → by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, other funct→000; aluop 11 unused → 000.

## Timing
- State register updates on rising clk; all outputs are combinational from state, plus funct (alucontrol) and zero (pcen); no registered outputs.
- Reset: state = FETCH at the first rising edge with reset=1; held while reset stays high. Post-reset outputs equal FETCH values: irwrite=1, pcen=1, alusrcb=01, alucontrol=010, all else 0. Datapath registers reset in the same cycle, so FETCH enables during reset are harmless.
- Reset mid-instruction aborts it: next state FETCH regardless of current state; no partial writeback after the reset edge.
- Cycles per instruction (FETCH through last state): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal op 2.
- pcen in BEQEX follows zero combinationally in the same cycle; the PC loads ALUOut at the BEQEX→FETCH edge only if zero=1.

## Structure
- Package mc_pkg: statetype enum (12 states above), opcode constants (OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J), funct constants, aluop 2-bit typedef, alucontrol codes shared with the ALU.
- Sub-module mc_aludec: combinational aluop+funct → alucontrol. Top holds the state register, next-state logic, output decode, and pcen gating.

## Test plan
- Reset then lw (op=100011): states FETCH,DECODE,MEMADR,MEMRD,MEMWB; MEMRD iord=1; MEMWB regwrite=1, memtoreg=1; back to FETCH on cycle 6.
- R-type sweep, op=000000, funct ∈ {100000,100010,100100,100101,101010,111111}: RTYPEEX alucontrol = 010,110,000,001,111,000; RTYPEWB regdst=1, regwrite=1.
- beq (op=000100) twice: zero=1 → pcen=1 in BEQEX with pcsrc=01, alucontrol=110; zero=0 → pcen=0; 3 cycles each.
- sw then j (000010): MEMWR memwrite=1, iord=1, regwrite=0; JEX pcsrc=10, pcen=1; j completes in 3 cycles.
- Illegal op 111111: DECODE→FETCH; no regwrite/memwrite asserted.
- reset=1 during MEMRD of lw: next state FETCH, no MEMWB cycle, outputs equal FETCH values.
